// File: rtl/irq_controller.sv
// Platform-level external interrupt controller.
//
// Collects NUM_SRC level-sensitive interrupt lines through per-source gateways,
// holds per-source enable/priority plus a global threshold, and registers the
// best pending source every cycle. ext_irq is raised whenever that best source
// exists. Software claims via a read of 0x0C and completes via a write of 0x0C.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   irq_src[NUM_SRC-1:0]   level interrupt lines, bit i-1 is source ID i
//   req_valid/req_ready    request handshake (req_ready = !resp_valid)
//   req_write, req_addr,   request direction, byte address, write data
//   req_wdata
//   resp_valid, resp_rdata one-cycle response pulse and read data
//   ext_irq                external interrupt request to the CSR file
module irq_controller #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [7:0]         req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               ext_irq
);

  localparam int unsigned IdW = 5;

  logic [NUM_SRC:1]  pending_q, pending_d;
  logic [NUM_SRC:1]  in_service_q, in_service_d;
  logic [NUM_SRC:1]  enable_q, enable_d;
  logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
  logic [PRIO_W-1:0] prio_d [1:NUM_SRC];
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [IdW-1:0]    best_id_q, best_id_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              accept;
  logic [5:0]        word_idx;
  logic              is_claim;
  logic              is_complete;
  logic [IdW-1:0]    cmpl_id;
  logic [31:0]       rdata;
  logic [PRIO_W-1:0] best_prio;
  logic              unused_bits;

  assign accept      = req_valid && !resp_valid_q;
  assign word_idx    = req_addr[7:2];
  assign is_claim    = accept && !req_write && (word_idx == 6'd3);
  assign is_complete = accept && req_write && (word_idx == 6'd3);
  assign cmpl_id     = req_wdata[IdW-1:0];
  assign unused_bits = ^{req_addr[1:0], req_wdata};

  assign req_ready  = !resp_valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign ext_irq    = (best_id_q != '0);

  // Read mux, sampled at the accept edge.
  always_comb begin
    rdata = '0;
    case (word_idx)
      6'd0: rdata = 32'({pending_q, 1'b0});
      6'd1: rdata = 32'({enable_q, 1'b0});
      6'd2: rdata = 32'(threshold_q);
      6'd3: rdata = 32'(best_id_q);
      default: begin
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
          if (word_idx == 6'(16 + i)) rdata = 32'(prio_q[i]);
        end
      end
    endcase
  end

  // Register writes and bus response.
  always_comb begin
    enable_d     = enable_q;
    threshold_d  = threshold_q;
    prio_d       = prio_q;
    resp_valid_d = accept;
    resp_rdata_d = '0;
    if (accept && !req_write) resp_rdata_d = rdata;
    if (accept && req_write) begin
      case (word_idx)
        6'd1: enable_d    = req_wdata[NUM_SRC:1];
        6'd2: threshold_d = req_wdata[PRIO_W-1:0];
        default: begin
          for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (word_idx == 6'(16 + i)) prio_d[i] = req_wdata[PRIO_W-1:0];
          end
        end
      endcase
    end
  end

  // Gateways, claim and complete. Busy is judged on the registered state, so a
  // claim or a fresh rise in the same cycle never produces a second pending.
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (irq_src[i-1] && !pending_q[i] && !in_service_q[i]) pending_d[i] = 1'b1;
      if (is_claim && (best_id_q == IdW'(i))) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
      if (is_complete && (cmpl_id == IdW'(i))) in_service_d[i] = 1'b0;
    end
  end

  // Arbiter: strict > against the running best keeps the lowest ID on ties,
  // and seeding with the threshold enforces priority > threshold.
  always_comb begin
    best_prio = threshold_q;
    best_id_d = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        best_id_d = IdW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      threshold_q  <= '0;
      best_id_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      best_id_q    <= best_id_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      prio_q       <= prio_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ext_irq;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  logic [31:0] exp_q [$];

  irq_controller #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .ext_irq    (ext_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation from the scoreboard.
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      check("ready_low_in_resp", 32'(req_ready), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got 0x%08h expected none", resp_rdata);
      end else begin
        check("resp_rdata", resp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
    bus(1'b1, addr, wd, 32'd0);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
    bus(1'b0, addr, 32'd0, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; irq_src = '0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("rst_ext_irq", 32'(ext_irq), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    rd(8'h00, 32'h0); rd(8'h04, 32'h0); rd(8'h08, 32'h0); rd(8'h4C, 32'h0);

    // Basic claim flow on source 3.
    wr(8'h4C, 32'd2); wr(8'h04, 32'h08); wr(8'h08, 32'd0);
    @(negedge clk) irq_src[2] = 1'b1;
    cyc(1); check("t1_ext_n1", 32'(ext_irq), 32'd0);
    cyc(1); check("t1_ext_n2", 32'(ext_irq), 32'd1);
    rd(8'h00, 32'h08);
    rd(8'h0C, 32'd3);
    check("t1_ext_after_claim_c1", 32'(ext_irq), 32'd1);
    cyc(1); check("t1_ext_after_claim", 32'(ext_irq), 32'd0);
    irq_src[2] = 1'b0;
    rd(8'h00, 32'h0);
    wr(8'h0C, 32'd3);

    // Priority ordering with a tie between 2 and 5.
    wr(8'h48, 32'd5); wr(8'h54, 32'd5); wr(8'h5C, 32'd6); wr(8'h04, 32'hA4);
    @(negedge clk) irq_src = 8'h52;
    @(negedge clk) irq_src = 8'h00;
    cyc(3);
    rd(8'h00, 32'hA4);
    rd(8'h0C, 32'd7); rd(8'h0C, 32'd2); rd(8'h0C, 32'd5); rd(8'h0C, 32'd0);
    wr(8'h0C, 32'd7); wr(8'h0C, 32'd2); wr(8'h0C, 32'd5);

    // Threshold masking.
    wr(8'h04, 32'h02); wr(8'h08, 32'd4); wr(8'h44, 32'd4);
    @(negedge clk) irq_src[0] = 1'b1;
    base = errors;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (ext_irq !== 1'b0) begin
        errors++;
        $display("FAIL t3_masked cycle %0d: got %0b expected 0", i, ext_irq);
      end
    end
    checks++;
    wr(8'h08, 32'd3);
    cyc(1); check("t3_ext_unmasked", 32'(ext_irq), 32'd1);
    rd(8'h0C, 32'd1);
    irq_src[0] = 1'b0;
    wr(8'h0C, 32'd1); wr(8'h08, 32'd0);

    // Held line: no re-pend while in service; re-pends after complete.
    wr(8'h04, 32'h10); wr(8'h50, 32'd1);
    @(negedge clk) irq_src[3] = 1'b1;
    cyc(3);
    rd(8'h0C, 32'd4);
    cyc(3);
    rd(8'h00, 32'h0);
    wr(8'h0C, 32'd4);
    cyc(2);
    rd(8'h00, 32'h10);
    rd(8'h0C, 32'd4);
    irq_src[3] = 1'b0;
    wr(8'h0C, 32'd4);
    cyc(3);
    rd(8'h00, 32'h0);
    check("t4_ext_idle", 32'(ext_irq), 32'd0);

    // Ignored completes leave source 4 in service.
    @(negedge clk) irq_src[3] = 1'b1;
    cyc(3);
    rd(8'h0C, 32'd4);
    irq_src[3] = 1'b0;
    wr(8'h0C, 32'd9); wr(8'h0C, 32'd2); wr(8'h0C, 32'd0);
    @(negedge clk) irq_src[3] = 1'b1;
    cyc(3);
    rd(8'h00, 32'h0);
    wr(8'h0C, 32'd4);
    cyc(2);
    rd(8'h00, 32'h10);
    rd(8'h0C, 32'd4);
    irq_src[3] = 1'b0;
    wr(8'h0C, 32'd4);

    // Register field widths and unmapped addresses.
    wr(8'h04, 32'hFFFF_FFFF); rd(8'h04, 32'h1FE); wr(8'h04, 32'h0);
    wr(8'h08, 32'hFF);        rd(8'h08, 32'd7);   wr(8'h08, 32'h0);
    wr(8'h60, 32'hF);         rd(8'h60, 32'd7);
    wr(8'h40, 32'h7);         rd(8'h40, 32'h0);
    rd(8'h64, 32'h0); rd(8'h10, 32'h0);
    wr(8'h00, 32'hFF); rd(8'h00, 32'h0);

    // Back-to-back requests: accepted every other cycle.
    @(negedge clk);
    base = resp_cnt;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    check("b2b_accepts", 32'(resp_cnt - base), 32'd2);

    // Reset in the middle of service.
    wr(8'h04, 32'h40); wr(8'h58, 32'd3);
    @(negedge clk) irq_src[5] = 1'b1;
    cyc(3);
    rd(8'h0C, 32'd6);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("rst2_ext_irq", 32'(ext_irq), 32'd0);
    check("rst2_resp_valid", 32'(resp_valid), 32'd0);
    check("rst2_req_ready", 32'(req_ready), 32'd1);
    rd(8'h04, 32'h0); rd(8'h08, 32'h0); rd(8'h58, 32'h0);
    rd(8'h00, 32'h40);
    rd(8'h0C, 32'd0);
    wr(8'h04, 32'h40); wr(8'h58, 32'd3);
    cyc(2); check("rst2_ext_repend", 32'(ext_irq), 32'd1);
    rd(8'h0C, 32'd6);
    irq_src[5] = 1'b0;
    wr(8'h0C, 32'd6);
    cyc(3);
    rd(8'h00, 32'h0);
    check("final_ext_irq", 32'(ext_irq), 32'd0);

    cyc(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
